// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Imported by the counter and by its later cascade wrapper.
package updown_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic [31:0] clamp_to_max(
    input logic [31:0] value,
    input logic [31:0] max
  );
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/updown_counter_param.sv
// Up/down counter with runtime wrap/saturate mode, load and enable.
// Registered carry/borrow pulses mark wraps for cascading stages.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = '1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_min
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_carry;
  logic             r_borrow;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;
  logic             w_carry;
  logic             w_borrow;
  logic             w_at_max;
  logic             w_at_min;

  assign w_load   = WIDTH'(clamp_to_max(32'(load_val), 32'(MAX_VAL)));
  assign w_at_max = (r_cnt == MAX_VAL);
  assign w_at_min = (r_cnt == '0);

  // Terminal count is compared explicitly so any modulus works.
  always_comb begin
    w_next   = r_cnt;
    w_carry  = 1'b0;
    w_borrow = 1'b0;
    if (load) begin
      w_next = w_load;
    end else if (en) begin
      if (up_down == DIR_UP) begin
        if (!w_at_max) begin
          w_next = r_cnt + WIDTH'(1);
        end else if (mode == MODE_WRAP) begin
          w_next  = '0;
          w_carry = 1'b1;
        end
      end else begin
        if (!w_at_min) begin
          w_next = r_cnt - WIDTH'(1);
        end else if (mode == MODE_WRAP) begin
          w_next   = MAX_VAL;
          w_borrow = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= RESET_VAL;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_cnt    <= w_next;
      r_carry  <= w_carry;
      r_borrow <= w_borrow;
    end
  end

  assign counter = r_cnt;
  assign carry   = r_carry;
  assign borrow  = r_borrow;
  assign at_max  = w_at_max;
  assign at_min  = w_at_min;

endmodule
